bank_resp_latency_tracker: RTL and testbench
============================================

BANK_RESP_LATENCY_TRACKER -- requirements
Module: bank_resp_latency_tracker

Interface
REQ-001 Parameter RANK, default 0, rank index of the tracked bank, used for identification only.
REQ-002 Parameter BANK, default 0, bank index of the tracked bank, used for identification only.
REQ-003 Parameter DEPTH, default 8, number of outstanding-request entries; legal range 2..32.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 globalCycle  in  64  free-running cycle count used for timestamps.
REQ-007 req_valid / req_ready  in / out  1 / 1  request issue handshake toward the bank; fires when both are high.
REQ-008 req_id, req_addr  in  32 each  ID and address of the issued request.
REQ-009 resp_valid  in  1  bank response present; always accepted, no backpressure.
REQ-010 resp_id, resp_addr, resp_data  in  32 each  ID, address and data of the response.
REQ-011 stat_fire  out  1  one-cycle strobe: a matched response record is valid.
REQ-012 stat_request_id, stat_addr, stat_data  out  32 each  registered copies of the matched response fields.
REQ-013 stat_cycle  out  64  globalCycle sampled when the response arrived.
REQ-014 stat_latency  out  32  response globalCycle minus issue globalCycle.
REQ-015 outstanding  out  6  number of valid table entries.
REQ-016 resp_count, orphan_count  out  32 each  matched responses / unmatched responses.
REQ-017 lat_min, lat_max  out  32 each  running minimum and maximum of stat_latency.
REQ-018 lat_sum  out  64  running sum of stat_latency.

Function
REQ-019 The table SHALL hold DEPTH entries of {valid, id[31:0], issue_cycle[63:0]}.
REQ-020 req_ready SHALL be the registered complement of "all entries valid"; it SHALL NOT depend combinationally on req_valid or resp_valid.
REQ-021 On a request fire, the block SHALL write the lowest-index invalid entry with req_id and the current globalCycle, and set it valid.
REQ-022 On resp_valid, the block SHALL compare resp_id against all valid entries; on a match it SHALL clear the lowest-index matching entry.
REQ-023 Duplicate outstanding IDs SHALL be permitted; responses SHALL retire them lowest-index first.
REQ-024 A matched response SHALL assert stat_fire exactly one cycle later (latency 1), with all stat_* fields registered.
REQ-025 stat_latency = globalCycle - issue_cycle as a 64-bit difference, saturated to 0xFFFFFFFF when the difference exceeds 32 bits.
REQ-026 On a matched response: resp_count += 1, lat_sum += latency, lat_min = min, lat_max = max; all updates visible in the same cycle as stat_fire.
REQ-027 An unmatched response SHALL increment orphan_count, SHALL NOT assert stat_fire, and SHALL leave the table unchanged.
REQ-028 resp_count, orphan_count and lat_sum SHALL saturate at all-ones and never wrap.
REQ-029 Simultaneous request fire and response SHALL both be processed in the same cycle; the request SHALL NOT take an entry freed in that cycle.
REQ-030 A response whose ID matches a request firing in the same cycle SHALL be treated as an orphan.
REQ-031 outstanding SHALL equal the popcount of valid bits; it updates one cycle after a fire or retirement.
REQ-032 stat_fire SHALL be high for exactly one cycle per matched response; back-to-back responses SHALL produce back-to-back strobes.

Reset
REQ-033 While reset is low, all entries SHALL be invalid, req_ready = 1, stat_fire = 0, and all stat_* fields, outstanding, resp_count, orphan_count, lat_max and lat_sum SHALL be 0.
REQ-034 While reset is low, lat_min SHALL be 0xFFFFFFFF.
REQ-035 Assertion of reset mid-operation SHALL discard all outstanding entries immediately; responses after reset release for those IDs SHALL count as orphans.

Verification
REQ-036 Request id=5 at globalCycle 100, response id=5 at 112 -> next cycle stat_fire=1, stat_latency=12, resp_count=1, lat_min=lat_max=12, lat_sum=12.
REQ-037 DEPTH=8: 8 requests without responses -> outstanding=8 and req_ready=0; one response -> req_ready=1 the cycle after retirement.
REQ-038 Response id=99 with nothing outstanding -> orphan_count=1, stat_fire stays 0, outstanding unchanged.
REQ-039 Two outstanding id=3 entries issued at cycles 10 and 20, responses at 30 and 31 -> latencies 20 then 11, in that order.
REQ-040 Full table, then same-cycle request and matching response -> request not accepted (req_ready=0 that cycle), entry freed, outstanding=7.
REQ-041 Reset low with 4 outstanding -> outstanding=0, lat_min=0xFFFFFFFF; a later response for one of those IDs -> orphan_count=1.

Source files
------------

// File: rtl/bank_resp_latency_tracker.sv
// Per-bank outstanding-request table that matches bank responses to issued requests
// and produces per-response latency records plus running latency statistics.
module bank_resp_latency_tracker #(
  parameter int RANK  = 0,
  parameter int BANK  = 0,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] globalCycle,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_id,
  input  logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_id,
  input  logic [31:0] resp_addr,
  input  logic [31:0] resp_data,
  output logic        stat_fire,
  output logic [31:0] stat_request_id,
  output logic [31:0] stat_addr,
  output logic [31:0] stat_data,
  output logic [63:0] stat_cycle,
  output logic [31:0] stat_latency,
  output logic [5:0]  outstanding,
  output logic [31:0] resp_count,
  output logic [31:0] orphan_count,
  output logic [31:0] lat_min,
  output logic [31:0] lat_max,
  output logic [63:0] lat_sum
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a request is issued on a cycle where req_valid and req_ready are both
  // high; req_ready is a register and never depends on this cycle's inputs.
  // Responses carry no ready and are taken whenever resp_valid is high.

  logic [DEPTH-1:0] valid;
  logic [31:0]      ids   [DEPTH];
  logic [63:0]      issue [DEPTH];

  logic             hit;
  logic [IW-1:0]    hit_idx;
  logic [IW-1:0]    free_idx;
  logic             match;
  logic             orphan;
  logic             fire;
  logic [DEPTH-1:0] valid_next;
  logic [63:0]      diff;
  logic [31:0]      lat;
  logic [64:0]      sum_ext;
  logic [63:0]      sum_next;

  // Identification parameters and the request address are carried for tracing only.
  logic unused_ok;
  assign unused_ok = ^{req_addr, 32'(RANK), 32'(BANK)};

  function automatic logic [5:0] count_ones(input logic [DEPTH-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  // Scan downward so the lowest index wins; the free slot comes from the current
  // valid bits, so an entry retired this cycle is never reused in the same cycle.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && ids[i] == resp_id) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid[i]) free_idx = IW'(i);
    end
  end

  always_comb begin
    fire   = req_valid && req_ready;
    match  = resp_valid && hit;
    orphan = resp_valid && !hit;
    valid_next = valid;
    if (match) valid_next[hit_idx] = 1'b0;
    if (fire)  valid_next[free_idx] = 1'b1;
    diff     = globalCycle - issue[hit_idx];
    lat      = (|diff[63:32]) ? 32'hFFFF_FFFF : diff[31:0];
    sum_ext  = {1'b0, lat_sum} + 65'(lat);
    sum_next = sum_ext[64] ? 64'hFFFF_FFFF_FFFF_FFFF : sum_ext[63:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid           <= '0;
      req_ready       <= 1'b1;
      outstanding     <= '0;
      stat_fire       <= 1'b0;
      stat_request_id <= '0;
      stat_addr       <= '0;
      stat_data       <= '0;
      stat_cycle      <= '0;
      stat_latency    <= '0;
      resp_count      <= '0;
      orphan_count    <= '0;
      lat_min         <= 32'hFFFF_FFFF;
      lat_max         <= '0;
      lat_sum         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ids[i]   <= '0;
        issue[i] <= '0;
      end
    end else begin
      valid       <= valid_next;
      req_ready   <= ~&valid_next;
      outstanding <= count_ones(valid_next);
      stat_fire   <= match;
      if (fire) begin
        ids[free_idx]   <= req_id;
        issue[free_idx] <= globalCycle;
      end
      if (match) begin
        stat_request_id <= resp_id;
        stat_addr       <= resp_addr;
        stat_data       <= resp_data;
        stat_cycle      <= globalCycle;
        stat_latency    <= lat;
        lat_sum         <= sum_next;
        if (resp_count != 32'hFFFF_FFFF) resp_count <= resp_count + 32'd1;
        if (lat < lat_min) lat_min <= lat;
        if (lat > lat_max) lat_max <= lat;
      end
      if (orphan && orphan_count != 32'hFFFF_FFFF) orphan_count <= orphan_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_bank_resp_latency_tracker.sv
// Directed bench for bank_resp_latency_tracker: one task per scenario, inline checks
// against hand-computed values, single summary line at the end.
module tb_bank_resp_latency_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] globalCycle;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_id;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_id;
  logic [31:0] resp_addr;
  logic [31:0] resp_data;
  logic        stat_fire;
  logic [31:0] stat_request_id;
  logic [31:0] stat_addr;
  logic [31:0] stat_data;
  logic [63:0] stat_cycle;
  logic [31:0] stat_latency;
  logic [5:0]  outstanding;
  logic [31:0] resp_count;
  logic [31:0] orphan_count;
  logic [31:0] lat_min;
  logic [31:0] lat_max;
  logic [63:0] lat_sum;

  int checks = 0;
  int failures = 0;

  bank_resp_latency_tracker #(.RANK(1), .BANK(2), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .globalCycle(globalCycle),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_addr(resp_addr), .resp_data(resp_data),
    .stat_fire(stat_fire), .stat_request_id(stat_request_id), .stat_addr(stat_addr),
    .stat_data(stat_data), .stat_cycle(stat_cycle), .stat_latency(stat_latency),
    .outstanding(outstanding), .resp_count(resp_count), .orphan_count(orphan_count),
    .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_id = '0; req_addr = '0;
    resp_valid = 1'b0; resp_id = '0; resp_addr = '0; resp_data = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle_inputs();
    globalCycle = '0;
    tick(); tick();
    reset = 1'b1;
  endtask

  // Drivers: each applies one cycle of stimulus and returns 1 ns after the edge.
  task automatic issue(input logic [31:0] id, input logic [63:0] gc);
    req_valid = 1'b1; req_id = id; req_addr = 32'hB000_0000 | id; globalCycle = gc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] id, input logic [63:0] gc);
    resp_valid = 1'b1; resp_id = id; resp_addr = 32'hA000_0000 | id;
    resp_data = 32'hD000_0000 | id; globalCycle = gc;
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    globalCycle = '0;
    tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    checks++; if (stat_fire !== 1'b0) begin failures++; $display("FAIL reset_stat_fire got=%0b exp=0", stat_fire); end
    checks++; if (outstanding !== 6'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++; if (resp_count !== 32'd0 || orphan_count !== 32'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", resp_count, orphan_count); end
    checks++; if (lat_min !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_lat_min got=%h exp=ffffffff", lat_min); end
    checks++; if (lat_max !== 32'd0 || lat_sum !== 64'd0) begin failures++; $display("FAIL reset_lat_max_sum got=%0d/%0d exp=0/0", lat_max, lat_sum); end
    checks++; if (stat_latency !== 32'd0 || stat_cycle !== 64'd0) begin failures++; $display("FAIL reset_stat_fields got=%0d/%0d exp=0/0", stat_latency, stat_cycle); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    issue(32'd5, 64'd100);
    checks++; if (outstanding !== 6'd1) begin failures++; $display("FAIL basic_outstanding_issue got=%0d exp=1", outstanding); end
    respond(32'd5, 64'd112);
    checks++; if (stat_fire !== 1'b1) begin failures++; $display("FAIL basic_stat_fire got=%0b exp=1", stat_fire); end
    checks++; if (stat_latency !== 32'd12) begin failures++; $display("FAIL basic_latency got=%0d exp=12", stat_latency); end
    checks++; if (stat_request_id !== 32'd5 || stat_addr !== 32'hA000_0005 || stat_data !== 32'hD000_0005) begin failures++; $display("FAIL basic_fields got=%h/%h/%h exp=5/a0000005/d0000005", stat_request_id, stat_addr, stat_data); end
    checks++; if (stat_cycle !== 64'd112) begin failures++; $display("FAIL basic_stat_cycle got=%0d exp=112", stat_cycle); end
    checks++; if (resp_count !== 32'd1 || lat_sum !== 64'd12) begin failures++; $display("FAIL basic_count_sum got=%0d/%0d exp=1/12", resp_count, lat_sum); end
    checks++; if (lat_min !== 32'd12 || lat_max !== 32'd12) begin failures++; $display("FAIL basic_min_max got=%0d/%0d exp=12/12", lat_min, lat_max); end
    checks++; if (outstanding !== 6'd0) begin failures++; $display("FAIL basic_outstanding_retire got=%0d exp=0", outstanding); end
    tick();
    checks++; if (stat_fire !== 1'b0) begin failures++; $display("FAIL basic_strobe_width got=%0b exp=0", stat_fire); end
  endtask

  task automatic test_orphan();
    respond(32'd99, 64'd200);
    checks++; if (orphan_count !== 32'd1) begin failures++; $display("FAIL orphan_count got=%0d exp=1", orphan_count); end
    checks++; if (stat_fire !== 1'b0) begin failures++; $display("FAIL orphan_stat_fire got=%0b exp=0", stat_fire); end
    checks++; if (outstanding !== 6'd0 || resp_count !== 32'd1) begin failures++; $display("FAIL orphan_side_effects got=%0d/%0d exp=0/1", outstanding, resp_count); end
  endtask

  task automatic test_back_to_back();
    issue(32'd3, 64'd10);
    issue(32'd3, 64'd20);
    respond(32'd3, 64'd30);
    checks++; if (stat_fire !== 1'b1 || stat_latency !== 32'd20) begin failures++; $display("FAIL dup_first fire=%0b lat=%0d exp=1/20", stat_fire, stat_latency); end
    respond(32'd3, 64'd31);
    checks++; if (stat_fire !== 1'b1 || stat_latency !== 32'd11) begin failures++; $display("FAIL dup_second fire=%0b lat=%0d exp=1/11", stat_fire, stat_latency); end
    checks++; if (resp_count !== 32'd3 || lat_sum !== 64'd43) begin failures++; $display("FAIL dup_count_sum got=%0d/%0d exp=3/43", resp_count, lat_sum); end
    checks++; if (lat_min !== 32'd11 || lat_max !== 32'd20) begin failures++; $display("FAIL dup_min_max got=%0d/%0d exp=11/20", lat_min, lat_max); end
    checks++; if (outstanding !== 6'd0) begin failures++; $display("FAIL dup_outstanding got=%0d exp=0", outstanding); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) issue(32'(10 + i), 64'(1000 + i));
    checks++; if (outstanding !== 6'd8) begin failures++; $display("FAIL full_outstanding got=%0d exp=8", outstanding); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_req_ready got=%0b exp=0", req_ready); end
    // Request id 50 offered while full, together with a response retiring id 12.
    req_valid = 1'b1; req_id = 32'd50;
    resp_valid = 1'b1; resp_id = 32'd12; resp_addr = 32'hA000_000C; resp_data = 32'hD000_000C;
    globalCycle = 64'd1100;
    tick();
    req_valid = 1'b0; resp_valid = 1'b0;
    checks++; if (outstanding !== 6'd7) begin failures++; $display("FAIL full_same_cycle_outstanding got=%0d exp=7", outstanding); end
    checks++; if (stat_fire !== 1'b1 || stat_latency !== 32'd98) begin failures++; $display("FAIL full_same_cycle_stat fire=%0b lat=%0d exp=1/98", stat_fire, stat_latency); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_retire got=%0b exp=1", req_ready); end
    checks++; if (lat_max !== 32'd98 || lat_sum !== 64'd141) begin failures++; $display("FAIL full_max_sum got=%0d/%0d exp=98/141", lat_max, lat_sum); end
    respond(32'd50, 64'd1101);
    checks++; if (orphan_count !== 32'd2 || stat_fire !== 1'b0) begin failures++; $display("FAIL full_rejected_req got=%0d/%0b exp=2/0", orphan_count, stat_fire); end
  endtask

  task automatic test_same_cycle_orphan();
    req_valid = 1'b1; req_id = 32'd60;
    resp_valid = 1'b1; resp_id = 32'd60;
    globalCycle = 64'd1200;
    tick();
    req_valid = 1'b0; resp_valid = 1'b0;
    checks++; if (orphan_count !== 32'd3 || stat_fire !== 1'b0) begin failures++; $display("FAIL same_cycle_orphan got=%0d/%0b exp=3/0", orphan_count, stat_fire); end
    checks++; if (outstanding !== 6'd8 || req_ready !== 1'b0) begin failures++; $display("FAIL same_cycle_accept got=%0d/%0b exp=8/0", outstanding, req_ready); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) issue(32'(20 + i), 64'(10 + i));
    checks++; if (outstanding !== 6'd4) begin failures++; $display("FAIL midrst_outstanding_before got=%0d exp=4", outstanding); end
    reset = 1'b0;
    #1;
    checks++; if (outstanding !== 6'd0 || req_ready !== 1'b1) begin failures++; $display("FAIL midrst_async_clear got=%0d/%0b exp=0/1", outstanding, req_ready); end
    checks++; if (lat_min !== 32'hFFFF_FFFF) begin failures++; $display("FAIL midrst_lat_min got=%h exp=ffffffff", lat_min); end
    tick();
    reset = 1'b1;
    tick();
    respond(32'd21, 64'd50);
    checks++; if (orphan_count !== 32'd1 || stat_fire !== 1'b0) begin failures++; $display("FAIL midrst_orphan got=%0d/%0b exp=1/0", orphan_count, stat_fire); end
  endtask

  task automatic test_saturation();
    issue(32'd7, 64'd0);
    respond(32'd7, 64'h1_0000_0005);
    checks++; if (stat_latency !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_latency got=%h exp=ffffffff", stat_latency); end
    checks++; if (lat_sum !== 64'hFFFF_FFFF || lat_max !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_sum_max got=%h/%h exp=ffffffff/ffffffff", lat_sum, lat_max); end
    issue(32'd8, 64'h1_0000_0000);
    respond(32'd8, 64'h1_0000_0003);
    checks++; if (stat_latency !== 32'd3 || lat_min !== 32'd3) begin failures++; $display("FAIL sat_wide_diff got=%0d/%0d exp=3/3", stat_latency, lat_min); end
    checks++; if (lat_sum !== 64'h1_0000_0002 || resp_count !== 32'd2) begin failures++; $display("FAIL sat_sum_after got=%h/%0d exp=100000002/2", lat_sum, resp_count); end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    globalCycle = '0;
    test_reset();
    test_basic();
    test_orphan();
    test_back_to_back();
    test_full();
    test_same_cycle_orphan();
    test_mid_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
